// File: rtl/world_dumper_pkg.sv
// world_dumper_pkg
//   Shared types and constants for the voxel world dump path.
//   block_type_t and the world extents match the l3 voxel cache; SYNC_BYTE
//   is the header byte that opens every dump frame.
//   Contents:
//     block_type_t      5-bit BlockType as stored in the cache
//     WORLD_LENGTH/WIDTH/HEIGHT  default world extents in x/y/z
//     CACHE_READ_LATENCY cycles from read strobe to valid read data
//     SYNC_BYTE          frame header byte
//     dump_state_t       world_dumper FSM states
//     coord_width()      counter width for an extent (never below 1 bit)
//     pack_block()       BlockType -> transmitted byte
package world_dumper_pkg;

    localparam int BLOCK_BITS = 5;
    typedef logic [BLOCK_BITS-1:0] block_type_t;

    localparam int WORLD_LENGTH       = 64;
    localparam int WORLD_WIDTH        = 64;
    localparam int WORLD_HEIGHT       = 16;
    localparam int CACHE_READ_LATENCY = 2;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_ISSUE,
        ST_WAIT,
        ST_SEND,
        ST_TRAILER,
        ST_DONE
    } dump_state_t;

    // An extent of 1 still needs a 1-bit counter so port widths stay legal.
    function automatic int coord_width(input int extent);
        return (extent > 1) ? $clog2(extent) : 1;
    endfunction

    function automatic logic [7:0] pack_block(input block_type_t block);
        return {3'b000, block};
    endfunction

endpackage

// File: rtl/world_dumper_coord_walker.sv
// coord_walker
//   Nested x/y/z scan counter: z innermost, then y, x outermost.
//   Each counter compares against extent-1 explicitly, so non-power-of-two
//   extents wrap correctly. The walk stops at the last coordinate.
//   Ports:
//     clk_in      system clock
//     rst_in      asynchronous active-low reset
//     clear_in    return to (0,0,0); wins over advance_in
//     advance_in  step to the next coordinate (ignored on the last one)
//     x_out/y_out/z_out  current coordinate
//     last_out    current coordinate is (LENGTH-1, WIDTH-1, HEIGHT-1)
module coord_walker
    import world_dumper_pkg::*;
#(
    parameter int  LENGTH = WORLD_LENGTH,
    parameter int  WIDTH  = WORLD_WIDTH,
    parameter int  HEIGHT = WORLD_HEIGHT,
    localparam int XW     = coord_width(LENGTH),
    localparam int YW     = coord_width(WIDTH),
    localparam int ZW     = coord_width(HEIGHT)
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          clear_in,
    input  logic          advance_in,
    output logic [XW-1:0] x_out,
    output logic [YW-1:0] y_out,
    output logic [ZW-1:0] z_out,
    output logic          last_out
);

    logic x_last;
    logic y_last;
    logic z_last;

    assign x_last   = (x_out == XW'(LENGTH - 1));
    assign y_last   = (y_out == YW'(WIDTH - 1));
    assign z_last   = (z_out == ZW'(HEIGHT - 1));
    assign last_out = x_last && y_last && z_last;

    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values of the others; blocking here would chain z->y->x
    // updates within one edge and break the carry order.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            x_out <= '0;
            y_out <= '0;
            z_out <= '0;
        end else if (clear_in) begin
            x_out <= '0;
            y_out <= '0;
            z_out <= '0;
        end else if (advance_in && !last_out) begin
            if (!z_last) begin
                z_out <= z_out + 1'b1;
            end else begin
                z_out <= '0;
                if (!y_last) begin
                    y_out <= y_out + 1'b1;
                end else begin
                    y_out <= '0;
                    x_out <= x_out + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/world_dumper.sv
// world_dumper
//   Streams the whole voxel world out of the l3 cache to the UART
//   transmitter as one frame: SYNC_BYTE, one byte per voxel in z/y/x scan
//   order ({3'b000, block}), then the XOR of all payload bytes.
//   One read is in flight at a time: ISSUE strobes the cache, WAIT counts
//   out the read latency, SEND offers the byte until the transmitter takes it.
//   Ports:
//     clk_in           system clock
//     rst_in           asynchronous active-low reset
//     start_in         begin a dump (looked at only while idle)
//     busy_out         high from the accepted start through the done cycle
//     done_out         one-cycle pulse after the trailer byte is accepted
//     x_out/y_out/z_out  cache read coordinate
//     read_enable_out  one-cycle cache read strobe
//     block_data_in    cache read data, READ_LATENCY cycles after the strobe
//     tx_data_out      byte for the UART transmitter
//     tx_valid_out     tx_data_out is valid
//     tx_ready_in      transmitter accepts the byte this cycle
module world_dumper #(
    parameter int          LENGTH       = world_dumper_pkg::WORLD_LENGTH,
    parameter int          WIDTH        = world_dumper_pkg::WORLD_WIDTH,
    parameter int          HEIGHT       = world_dumper_pkg::WORLD_HEIGHT,
    parameter int          READ_LATENCY = world_dumper_pkg::CACHE_READ_LATENCY,
    parameter logic [7:0]  SYNC_BYTE    = world_dumper_pkg::SYNC_BYTE,
    localparam int         XW           = world_dumper_pkg::coord_width(LENGTH),
    localparam int         YW           = world_dumper_pkg::coord_width(WIDTH),
    localparam int         ZW           = world_dumper_pkg::coord_width(HEIGHT)
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          start_in,
    output logic          busy_out,
    output logic          done_out,
    output logic [XW-1:0] x_out,
    output logic [YW-1:0] y_out,
    output logic [ZW-1:0] z_out,
    output logic          read_enable_out,
    input  logic [4:0]    block_data_in,
    output logic [7:0]    tx_data_out,
    output logic          tx_valid_out,
    input  logic          tx_ready_in
);

    import world_dumper_pkg::*;

    // Wide enough to hold READ_LATENCY itself. READ_LATENCY must be >= 1.
    localparam int LW = coord_width(READ_LATENCY + 1);

    dump_state_t   state_q;
    dump_state_t   state_d;
    logic [LW-1:0] lat_cnt_q;
    logic [7:0]    data_q;
    logic [7:0]    checksum_q;

    logic          walk_clear;
    logic          walk_advance;
    logic          walk_last;
    logic          capture;

    coord_walker #(
        .LENGTH (LENGTH),
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_walker (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .clear_in   (walk_clear),
        .advance_in (walk_advance),
        .x_out      (x_out),
        .y_out      (y_out),
        .z_out      (z_out),
        .last_out   (walk_last)
    );

    // Outputs decode state_q only, so tx_valid_out never depends on
    // tx_ready_in and drops as soon as the async reset clears the state.
    // tx_data_out comes from registers that are frozen in HEADER/SEND/TRAILER,
    // which keeps it stable while a byte is stalled.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned; a missing default here infers a latch.
        state_d         = state_q;
        busy_out        = 1'b1;
        done_out        = 1'b0;
        read_enable_out = 1'b0;
        tx_valid_out    = 1'b0;
        tx_data_out     = 8'h00;
        walk_clear      = 1'b0;
        walk_advance    = 1'b0;
        capture         = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                busy_out = 1'b0;
                if (start_in) begin
                    walk_clear = 1'b1;
                    state_d    = ST_HEADER;
                end
            end
            ST_HEADER: begin
                tx_valid_out = 1'b1;
                tx_data_out  = SYNC_BYTE;
                if (tx_ready_in) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                read_enable_out = 1'b1;
                state_d         = ST_WAIT;
            end
            ST_WAIT: begin
                // Counter at 1 means this decrement reaches 0: the cache
                // data is valid in this very cycle.
                if (lat_cnt_q == LW'(1)) begin
                    capture = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                tx_valid_out = 1'b1;
                tx_data_out  = data_q;
                if (tx_ready_in) begin
                    if (walk_last) begin
                        state_d = ST_TRAILER;
                    end else begin
                        walk_advance = 1'b1;
                        state_d      = ST_ISSUE;
                    end
                end
            end
            ST_TRAILER: begin
                tx_valid_out = 1'b1;
                tx_data_out  = checksum_q;
                if (tx_ready_in) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_out = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                busy_out = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // NOTE: only control and datapath flops live here and all of them take
    // the async reset; there is no storage array that would need to be left
    // out of the reset branch.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= ST_IDLE;
            lat_cnt_q  <= '0;
            data_q     <= '0;
            checksum_q <= '0;
        end else begin
            state_q <= state_d;

            if (state_q == ST_ISSUE) begin
                lat_cnt_q <= LW'(READ_LATENCY);
            end else if (state_q == ST_WAIT) begin
                lat_cnt_q <= lat_cnt_q - 1'b1;
            end

            if (walk_clear) begin
                checksum_q <= '0;
            end else if (capture) begin
                checksum_q <= checksum_q ^ pack_block(block_data_in);
            end

            if (capture) begin
                data_q <= pack_block(block_data_in);
            end
        end
    end

endmodule

// File: tb/tb_world_dumper.sv
// tb_world_dumper
//   Small 2x2x2 world. A cache model answers reads READ_LATENCY cycles
//   after the strobe from a lookup table (junk data at every other time).
//   The expected frame is built directly from the table: header, one byte
//   per voxel in linear x*W*H + y*H + z order, XOR trailer.
module tb_world_dumper;

    localparam int         LENGTH  = 2;
    localparam int         WIDTH   = 2;
    localparam int         HEIGHT  = 2;
    localparam int         RL      = 2;
    localparam logic [7:0] SYNC    = 8'hA5;
    localparam int         N       = LENGTH * WIDTH * HEIGHT;
    localparam int         MAX_CYC = 2000;

    logic       clk_in;
    logic       rst_in;
    logic       start_in;
    logic       busy_out;
    logic       done_out;
    logic [0:0] x_out;
    logic [0:0] y_out;
    logic [0:0] z_out;
    logic       read_enable_out;
    logic [4:0] block_data_in;
    logic [7:0] tx_data_out;
    logic       tx_valid_out;
    logic       tx_ready_in;

    world_dumper #(
        .LENGTH       (LENGTH),
        .WIDTH        (WIDTH),
        .HEIGHT       (HEIGHT),
        .READ_LATENCY (RL),
        .SYNC_BYTE    (SYNC)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .start_in        (start_in),
        .busy_out        (busy_out),
        .done_out        (done_out),
        .x_out           (x_out),
        .y_out           (y_out),
        .z_out           (z_out),
        .read_enable_out (read_enable_out),
        .block_data_in   (block_data_in),
        .tx_data_out     (tx_data_out),
        .tx_valid_out    (tx_valid_out),
        .tx_ready_in     (tx_ready_in)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // ---------------- cache model ----------------
    logic [4:0] lut [N];
    logic [4:0] pipe_d [RL];
    logic       pipe_v [RL];
    logic [4:0] junk;
    int         lin_index;

    assign lin_index = int'(x_out) * WIDTH * HEIGHT + int'(y_out) * HEIGHT + int'(z_out);

    initial begin
        for (int i = 0; i < RL; i++) begin
            pipe_v[i] = 1'b0;
            pipe_d[i] = '0;
        end
        junk = '0;
    end

    always @(posedge clk_in) begin
        pipe_v[0] <= read_enable_out;
        pipe_d[0] <= lut[lin_index];
        for (int i = 1; i < RL; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
        end
        junk <= 5'($urandom);
    end

    assign block_data_in = pipe_v[RL-1] ? pipe_d[RL-1] : junk;

    // ---------------- bookkeeping ----------------
    int n_checks;
    int n_pass;

    logic [7:0] exp_bytes[$];
    logic [7:0] got_bytes[$];
    int         got_times[$];
    int         got_reads[$];
    int         done_count;
    int         stall_bad;
    int         busy_bad;
    int         post_busy;
    bit         timed_out;
    bit         aborted;

    // Reference frame straight from the lookup table.
    task automatic build_expected();
        logic [7:0] cs;
        cs = 8'h00;
        exp_bytes.delete();
        exp_bytes.push_back(SYNC);
        for (int i = 0; i < N; i++) begin
            exp_bytes.push_back({3'b000, lut[i]});
            cs = cs ^ {3'b000, lut[i]};
        end
        exp_bytes.push_back(cs);
    endtask

    // Drives one dump and records everything seen at negedges.
    // abort_at > 0: stop (leaving the DUT mid-frame) once that many bytes have
    // transferred and the next byte is being offered.
    task automatic run_frame(input bit rand_ready, input bit poke_start, input int abort_at);
        bit         prev_stall;
        logic [7:0] prev_data;
        got_bytes.delete();
        got_times.delete();
        got_reads.delete();
        done_count = 0;
        stall_bad  = 0;
        busy_bad   = 0;
        post_busy  = 0;
        timed_out  = 1'b1;
        aborted    = 1'b0;
        prev_stall = 1'b0;
        prev_data  = 8'h00;

        @(negedge clk_in);
        start_in    = 1'b1;
        tx_ready_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;

        for (int cyc = 0; cyc < MAX_CYC; cyc++) begin
            if (prev_stall && (tx_valid_out !== 1'b1 || tx_data_out !== prev_data)) stall_bad++;
            if (busy_out !== 1'b1) busy_bad++;
            if (read_enable_out === 1'b1) begin
                got_reads.push_back(lin_index);
            end
            if (abort_at > 0 && tx_valid_out === 1'b1 && got_bytes.size() == abort_at) begin
                aborted   = 1'b1;
                timed_out = 1'b0;
                break;
            end
            start_in    = poke_start && (done_out === 1'b1 || cyc == 9);
            tx_ready_in = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (tx_valid_out === 1'b1 && tx_ready_in) begin
                got_bytes.push_back(tx_data_out);
                got_times.push_back(cyc);
            end
            prev_stall = (tx_valid_out === 1'b1) && !tx_ready_in;
            prev_data  = tx_data_out;
            if (done_out === 1'b1) begin
                done_count++;
                timed_out = 1'b0;
                break;
            end
            @(negedge clk_in);
        end

        if (!aborted && !timed_out) begin
            @(negedge clk_in);
            start_in    = 1'b0;
            tx_ready_in = 1'b1;
            repeat (6) begin
                if (busy_out !== 1'b0 || done_out !== 1'b0) post_busy++;
                @(negedge clk_in);
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_in      = 1'b0;
        start_in    = 1'b0;
        tx_ready_in = 1'b0;
        repeat (3) @(negedge clk_in);
        n_checks++; if (busy_out !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_out); else n_pass++;
        n_checks++; if (done_out !== 1'b0) $display("FAIL reset_done: got %b want 0", done_out); else n_pass++;
        n_checks++; if (tx_valid_out !== 1'b0) $display("FAIL reset_valid: got %b want 0", tx_valid_out); else n_pass++;
        n_checks++; if (tx_data_out !== 8'h00) $display("FAIL reset_data: got %h want 00", tx_data_out); else n_pass++;
        n_checks++; if (read_enable_out !== 1'b0) $display("FAIL reset_re: got %b want 0", read_enable_out); else n_pass++;
        n_checks++; if ({x_out, y_out, z_out} !== 3'b000) $display("FAIL reset_coord: got %b want 000", {x_out, y_out, z_out}); else n_pass++;
        rst_in = 1'b1;
        @(negedge clk_in);
    endtask

    task automatic test_frame_ready_high();
        for (int i = 0; i < N; i++) lut[i] = 5'(i + 1);
        build_expected();
        run_frame(1'b0, 1'b0, 0);
        n_checks++; if (timed_out) $display("FAIL hi_timeout: got timeout want done"); else n_pass++;
        n_checks++; if (got_bytes.size() != N + 2) $display("FAIL hi_len: got %0d want %0d", got_bytes.size(), N + 2); else n_pass++;
        for (int i = 0; i < got_bytes.size() && i < exp_bytes.size(); i++) begin
            n_checks++;
            if (got_bytes[i] !== exp_bytes[i]) $display("FAIL hi_byte%0d: got %h want %h", i, got_bytes[i], exp_bytes[i]);
            else n_pass++;
        end
        n_checks++; if (done_count != 1) $display("FAIL hi_done: got %0d want 1", done_count); else n_pass++;
        n_checks++; if (busy_bad != 0) $display("FAIL hi_busy: got %0d low cycles want 0", busy_bad); else n_pass++;
        n_checks++; if (post_busy != 0) $display("FAIL hi_idle_after: got %0d active cycles want 0", post_busy); else n_pass++;
        n_checks++; if (got_reads.size() != N) $display("FAIL hi_reads: got %0d want %0d", got_reads.size(), N); else n_pass++;
        // With the transmitter always ready, payload bytes leave every RL+2 cycles.
        for (int i = 2; i <= N && i < got_times.size(); i++) begin
            n_checks++;
            if (got_times[i] - got_times[i-1] != RL + 2)
                $display("FAIL hi_rate%0d: got %0d cycles want %0d", i, got_times[i] - got_times[i-1], RL + 2);
            else n_pass++;
        end
    endtask

    task automatic test_frame_random_ready();
        for (int i = 0; i < N; i++) lut[i] = 5'($urandom);
        build_expected();
        run_frame(1'b1, 1'b0, 0);
        n_checks++; if (timed_out) $display("FAIL rnd_timeout: got timeout want done"); else n_pass++;
        n_checks++; if (got_bytes.size() != N + 2) $display("FAIL rnd_len: got %0d want %0d", got_bytes.size(), N + 2); else n_pass++;
        for (int i = 0; i < got_bytes.size() && i < exp_bytes.size(); i++) begin
            n_checks++;
            if (got_bytes[i] !== exp_bytes[i]) $display("FAIL rnd_byte%0d: got %h want %h", i, got_bytes[i], exp_bytes[i]);
            else n_pass++;
        end
        n_checks++; if (stall_bad != 0) $display("FAIL rnd_stable: got %0d changes while stalled want 0", stall_bad); else n_pass++;
        n_checks++; if (got_reads.size() != N) $display("FAIL rnd_reads: got %0d want %0d", got_reads.size(), N); else n_pass++;
        for (int i = 0; i < got_reads.size() && i < N; i++) begin
            n_checks++;
            if (got_reads[i] != i) $display("FAIL rnd_coord%0d: got index %0d want %0d", i, got_reads[i], i);
            else n_pass++;
        end
        n_checks++; if (done_count != 1) $display("FAIL rnd_done: got %0d want 1", done_count); else n_pass++;
    endtask

    task automatic test_start_ignored();
        for (int i = 0; i < N; i++) lut[i] = 5'(i + 1);
        build_expected();
        run_frame(1'b0, 1'b1, 0);
        n_checks++; if (got_bytes.size() != N + 2) $display("FAIL ign_len: got %0d want %0d", got_bytes.size(), N + 2); else n_pass++;
        for (int i = 0; i < got_bytes.size() && i < exp_bytes.size(); i++) begin
            n_checks++;
            if (got_bytes[i] !== exp_bytes[i]) $display("FAIL ign_byte%0d: got %h want %h", i, got_bytes[i], exp_bytes[i]);
            else n_pass++;
        end
        n_checks++; if (done_count != 1) $display("FAIL ign_done: got %0d want 1", done_count); else n_pass++;
        n_checks++; if (post_busy != 0) $display("FAIL ign_restart: got %0d active cycles want 0", post_busy); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < N; i++) lut[i] = 5'($urandom);
        build_expected();
        // Header plus three payload bytes sent, fourth payload byte on offer.
        run_frame(1'b0, 1'b0, 4);
        n_checks++; if (!aborted) $display("FAIL mid_reach: got no 4th payload byte want one"); else n_pass++;
        rst_in = 1'b0;
        #1;
        n_checks++; if (tx_valid_out !== 1'b0) $display("FAIL mid_valid: got %b want 0", tx_valid_out); else n_pass++;
        n_checks++; if (busy_out !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy_out); else n_pass++;
        @(negedge clk_in);
        rst_in = 1'b1;
        run_frame(1'b1, 1'b0, 0);
        n_checks++; if (got_bytes.size() != N + 2) $display("FAIL mid_len: got %0d want %0d", got_bytes.size(), N + 2); else n_pass++;
        for (int i = 0; i < got_bytes.size() && i < exp_bytes.size(); i++) begin
            n_checks++;
            if (got_bytes[i] !== exp_bytes[i]) $display("FAIL mid_byte%0d: got %h want %h", i, got_bytes[i], exp_bytes[i]);
            else n_pass++;
        end
    endtask

    task automatic test_all_1f();
        for (int i = 0; i < N; i++) lut[i] = 5'h1F;
        build_expected();
        run_frame(1'b1, 1'b0, 0);
        n_checks++; if (got_bytes.size() != N + 2) $display("FAIL f_len: got %0d want %0d", got_bytes.size(), N + 2); else n_pass++;
        for (int i = 0; i < got_bytes.size() && i < exp_bytes.size(); i++) begin
            n_checks++;
            if (got_bytes[i] !== exp_bytes[i]) $display("FAIL f_byte%0d: got %h want %h", i, got_bytes[i], exp_bytes[i]);
            else n_pass++;
        end
        n_checks++; if (got_bytes.size() > 0 && got_bytes[got_bytes.size()-1] !== 8'h00)
            $display("FAIL f_checksum: got %h want 00", got_bytes[got_bytes.size()-1]); else n_pass++;
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        rst_in      = 1'b0;
        start_in    = 1'b0;
        tx_ready_in = 1'b0;
        for (int i = 0; i < N; i++) lut[i] = '0;

        test_reset();
        test_frame_ready_high();
        test_frame_random_ready();
        test_start_ignored();
        test_reset_mid_frame();
        test_all_1f();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
